// File: rtl/target_net_state_loader.sv
// Writes N state words into target_net's input RAM, fires its start pulse, then
// returns the max-Q result (or a timeout pulse) to the caller.
module target_net_state_loader #(
  parameter int DATA_WIDTH           = 32,
  parameter int ADDRESS_WIDTH        = 5,
  parameter int NUMBER_OF_INPUT_NODE = 2,
  parameter int BASE_ADDRESS         = 0,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_wr_en,
  output logic [ADDRESS_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0]    o_wr_data,
  output logic                     o_net_valid,
  input  logic [DATA_WIDTH-1:0]    i_net_data,
  input  logic                     i_net_valid,
  output logic [DATA_WIDTH-1:0]    o_q_max,
  output logic                     o_q_valid,
  output logic                     o_timeout
);

  localparam int CNT_W = (NUMBER_OF_INPUT_NODE > 1) ? $clog2(NUMBER_OF_INPUT_NODE) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUMBER_OF_INPUT_NODE - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {LOAD, START, WAIT} state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic [TMR_W-1:0]         timer, timer_next;
  logic                     wr_en_next, net_valid_next, q_valid_next, timeout_next;
  logic [ADDRESS_WIDTH-1:0] wr_addr_next;
  logic [DATA_WIDTH-1:0]    wr_data_next, q_max_next;

  // Handshake: a word transfers on a rising edge where i_valid && o_ready; o_ready is high only in LOAD.
  assign o_ready = (state == LOAD);

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    timer_next     = timer;
    wr_en_next     = 1'b0;
    wr_addr_next   = o_wr_addr;
    wr_data_next   = o_wr_data;
    net_valid_next = 1'b0;
    q_max_next     = o_q_max;
    q_valid_next   = 1'b0;
    timeout_next   = 1'b0;
    case (state)
      LOAD: begin
        if (i_valid) begin
          wr_en_next   = 1'b1;
          wr_addr_next = ADDRESS_WIDTH'(BASE_ADDRESS) + ADDRESS_WIDTH'(cnt);
          wr_data_next = i_data;
          if (cnt == LAST_WORD) begin
            cnt_next   = '0;
            state_next = START;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      START: begin
        net_valid_next = 1'b1;
        timer_next     = '0;
        state_next     = WAIT;
      end
      WAIT: begin
        timer_next = timer + TMR_W'(1);
        // A result arriving on the deadline cycle still counts as on time.
        if (i_net_valid) begin
          q_max_next   = i_net_data;
          q_valid_next = 1'b1;
          timer_next   = '0;
          state_next   = LOAD;
        end else if (timer == TMR_LAST) begin
          timeout_next = 1'b1;
          timer_next   = '0;
          state_next   = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      cnt         <= '0;
      timer       <= '0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_net_valid <= 1'b0;
      o_q_max     <= '0;
      o_q_valid   <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      timer       <= timer_next;
      o_wr_en     <= wr_en_next;
      o_wr_addr   <= wr_addr_next;
      o_wr_data   <= wr_data_next;
      o_net_valid <= net_valid_next;
      o_q_max     <= q_max_next;
      o_q_valid   <= q_valid_next;
      o_timeout   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_target_net_state_loader.sv
// Bench for target_net_state_loader: event-level reference model feeding expected
// queues, and a negedge monitor that pops and compares every DUT output event.
module tb_target_net_state_loader;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int N    = 2;
  localparam int BASE = 4;
  localparam int T    = 16;
  localparam int INF  = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_net_valid;
  logic [DW-1:0] i_net_data = '0;
  logic          i_net_valid = 1'b0;
  logic [DW-1:0] o_q_max;
  logic          o_q_valid;
  logic          o_timeout;

  target_net_state_loader #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUMBER_OF_INPUT_NODE(N),
    .BASE_ADDRESS(BASE), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_net_valid(o_net_valid), .i_net_data(i_net_data), .i_net_valid(i_net_valid),
    .o_q_max(o_q_max), .o_q_valid(o_q_valid), .o_timeout(o_timeout)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [32+AW+DW-1:0] wr_q[$];   // {cycle, addr, data}
  logic [32+DW-1:0]    res_q[$];  // {cycle, q value}
  logic [31:0]         net_q[$];  // cycle of start pulse
  logic [31:0]         to_q[$];   // cycle of timeout pulse

  int          m_k;
  int          m_ready_from;
  int          m_wait_from;
  logic [DW-1:0] m_last_q;
  bit          ready_exp = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at cycle %0d: unexpected event, none required", name, cyc);
  endtask

  task automatic missing(input string name, input int when);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event required at cycle %0d not seen by cycle %0d", name, when, cyc);
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_k          = 0;
    m_ready_from = 0;
    m_wait_from  = INF;
    m_last_q     = '0;
    wr_q.delete();
    res_q.delete();
    net_q.delete();
    to_q.delete();
  endtask

  // Inputs held during cycle c take effect on the outputs of cycle c+1.
  task automatic model_step(input bit v, input logic [DW-1:0] d, input bit nv, input logic [DW-1:0] nd);
    int c;
    c = cyc;
    if (c >= m_ready_from) begin
      if (v) begin
        wr_q.push_back({32'(c + 1), AW'(BASE + m_k), d});
        m_k++;
        if (m_k == N) begin
          m_k          = 0;
          net_q.push_back(32'(c + 2));
          m_wait_from  = c + 2;
          m_ready_from = INF;
        end
      end
    end else if (c >= m_wait_from) begin
      if (nv) begin
        res_q.push_back({32'(c + 1), nd});
        m_last_q     = nd;
        m_ready_from = c + 1;
      end else if (c == m_wait_from + T - 1) begin
        to_q.push_back(32'(c + 1));
        m_ready_from = c + 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit nv, input logic [DW-1:0] nd);
    tick();
    check("q_max_hold", o_q_max, m_last_q);
    i_valid     = v;
    i_data      = d;
    i_net_valid = nv;
    i_net_data  = nd;
    ready_exp   = (cyc >= m_ready_from);
    model_step(v, d, nv, nd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0);
  endtask

  // Asserts reset in the middle of the current cycle, aborting whatever is in flight.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs_zero",
          {o_wr_en, o_wr_addr, o_wr_data, o_net_valid, o_q_max, o_q_valid, o_timeout}, '0);
    model_reset();
    i_valid     = 1'b0;
    i_net_valid = 1'b0;
    tick();
    tick();
    rst_n     = 1'b1;
    ready_exp = 1'b1;
    check("ready_after_reset", o_ready, 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [32+AW+DW-1:0] ew;
    logic [32+DW-1:0]    er;
    logic [31:0]         ec;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      check("ready", o_ready, ready_exp);
      if (o_wr_en) begin
        if (wr_q.size() == 0) unexpected("write");
        else begin
          ew = wr_q.pop_front();
          check("write{cycle,addr,data}", {32'(cyc), o_wr_addr, o_wr_data}, ew);
        end
      end
      if (o_net_valid) begin
        if (net_q.size() == 0) unexpected("net_start");
        else begin
          ec = net_q.pop_front();
          check("net_start_cycle", 32'(cyc), ec);
        end
      end
      if (o_q_valid) begin
        if (res_q.size() == 0) unexpected("q_valid");
        else begin
          er = res_q.pop_front();
          check("q_result{cycle,q_max}", {32'(cyc), o_q_max}, er);
        end
      end
      if (o_timeout) begin
        if (to_q.size() == 0) unexpected("timeout");
        else begin
          ec = to_q.pop_front();
          check("timeout_cycle", 32'(cyc), ec);
          check("q_max_on_timeout", o_q_max, m_last_q);
        end
      end
      while (wr_q.size() > 0 && int'(wr_q[0][AW+DW +: 32]) < cyc) begin
        missing("write", int'(wr_q[0][AW+DW +: 32]));
        void'(wr_q.pop_front());
      end
      while (net_q.size() > 0 && int'(net_q[0]) < cyc) begin
        missing("net_start", int'(net_q[0]));
        void'(net_q.pop_front());
      end
      while (res_q.size() > 0 && int'(res_q[0][DW +: 32]) < cyc) begin
        missing("q_valid", int'(res_q[0][DW +: 32]));
        void'(res_q.pop_front());
      end
      while (to_q.size() > 0 && int'(to_q[0]) < cyc) begin
        missing("timeout", int'(to_q[0]));
        void'(to_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    tick();
    tick();
    check("reset_state_outputs",
          {o_wr_en, o_wr_addr, o_wr_data, o_net_valid, o_q_max, o_q_valid, o_timeout}, '0);
    rst_n = 1'b1;
    check("reset_state_ready", o_ready, 1'b1);

    // basic load then result after a 10-cycle wait
    cycle(1'b1, 32'h3F80_0000, 1'b0, '0);
    cycle(1'b1, 32'h4000_0000, 1'b0, '0);
    idle(10);
    cycle(1'b0, '0, 1'b1, 32'h4040_0000);
    idle(3);

    // gapped input
    cycle(1'b1, 32'h1111_0001, 1'b0, '0);
    cycle(1'b0, 32'h2222_0002, 1'b0, '0);
    cycle(1'b0, 32'h3333_0003, 1'b0, '0);
    cycle(1'b1, 32'h4444_0004, 1'b0, '0);
    idle(4);
    cycle(1'b0, '0, 1'b1, 32'hBF80_0000);
    idle(2);

    // result valid during LOAD is ignored
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 32'h1234_5678);
    idle(1);

    // words during WAIT dropped, then timeout, then late result ignored
    cycle(1'b1, 32'h0000_00A1, 1'b0, '0);
    cycle(1'b1, 32'h0000_00A2, 1'b0, '0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'hDEAD_BEEF, 1'b0, '0);
    idle(8);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 32'hCAFE_F00D);
    idle(2);

    // reset while waiting
    cycle(1'b1, 32'h0000_00B1, 1'b0, '0);
    cycle(1'b1, 32'h0000_00B2, 1'b0, '0);
    idle(4);
    do_reset();
    // reset mid-load, one word already written
    cycle(1'b1, 32'h0000_00C1, 1'b0, '0);
    idle(1);
    do_reset();
    cycle(1'b1, 32'h0000_00D1, 1'b0, '0);
    cycle(1'b1, 32'h0000_00D2, 1'b0, '0);
    idle(5);
    cycle(1'b0, '0, 1'b1, 32'h4100_0000);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) == 0), $urandom);
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    idle(2 * T + 4);
    check("writes_drained", wr_q.size(), 0);
    check("starts_drained", net_q.size(), 0);
    check("results_drained", res_q.size(), 0);
    check("timeouts_drained", to_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/target_net_state_loader.md
Name: target_net_state_loader

Overview:
- Initiator-side controller for the target network.
- Accepts a serial stream of state words (IEEE-754 single, DATA_WIDTH bits) and writes them into the target network's input-data RAM, then fires the network's start pulse.
- Waits for the max-Q result (the target net's o_data/o_valid) and returns it to the caller with a one-cycle valid.
- Sits between the DQN training controller and target_net. It is the writer/requester end of the interface that target_net reads from and responds on.

Parameters:
- DATA_WIDTH, 32, width of state words and Q value.
- ADDRESS_WIDTH, 5, width of the input-RAM write address.
- NUMBER_OF_INPUT_NODE, 2, number of state words per inference (1..2^ADDRESS_WIDTH).
- BASE_ADDRESS, 0, RAM address of state word 0.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for the result after start (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- i_data  input  DATA_WIDTH  state word from the caller.
- i_valid  input  1  i_data valid; a word is accepted when i_valid && o_ready.
- o_ready  output  1  loader can accept a state word.
- o_wr_en  output  1  input-RAM write enable.
- o_wr_addr  output  ADDRESS_WIDTH  input-RAM write address.
- o_wr_data  output  DATA_WIDTH  input-RAM write data.
- o_net_valid  output  1  start pulse to target_net i_valid.
- i_net_data  input  DATA_WIDTH  max-Q value from target_net.
- i_net_valid  input  1  target_net result valid.
- o_q_max  output  DATA_WIDTH  captured max-Q value.
- o_q_valid  output  1  one-cycle pulse when o_q_max updates.
- o_timeout  output  1  one-cycle pulse when the result does not arrive in time.

Behaviour:
- Reset (async, rst_n=0): state=LOAD, word counter=0, timer=0. All outputs are 0 except o_ready, which is 1 once in LOAD (o_ready is a decode of state). Reset mid-operation aborts immediately; no partial write is completed and no pulse is issued.
- All outputs are registered except o_ready, which is combinational from state.
- FSM states: LOAD, START, WAIT.

LOAD:
- o_ready=1.
- On an accepted word k (k = 0..N-1), the next cycle has o_wr_en=1, o_wr_addr=BASE_ADDRESS+k (mod 2^ADDRESS_WIDTH), o_wr_data=i_data. Write latency is 1 cycle.
- Back-to-back words are accepted every cycle.
- On acceptance of word N-1: counter clears to 0 and state->START.
- i_valid=0 leaves the counter unchanged, with no write.

START (exactly 1 cycle):
- o_ready=0.
- This is the cycle in which the last o_wr_en is high. o_net_valid=1 in the following cycle, exactly one cycle wide.
- State->WAIT and timer clears.

WAIT:
- o_ready=0.
- i_valid is ignored; words are dropped and no write occurs.
- Timer increments every cycle.
- If i_net_valid=1: o_q_max<=i_net_data, o_q_valid=1 the next cycle, state->LOAD.
- Else if timer==TIMEOUT_CYCLES-1: o_timeout=1 the next cycle, o_q_max unchanged, state->LOAD.
- If i_net_valid and timeout occur in the same cycle, the result wins and o_timeout stays 0.

Other rules:
- i_net_valid outside WAIT is ignored; o_q_max is not updated.
- o_q_max holds its last value until the next capture. The reset value is 0.
- First-word acceptance is possible in the cycle after return to LOAD, i.e. the cycle in which o_q_valid or o_timeout is high.
- No arithmetic is performed on data; words pass bit-exact.

Test Plan:
- Basic load. N=2. Drive i_data=0x3F800000 then 0x40000000 on consecutive cycles. Required: o_wr_en on 2 consecutive cycles with addr 0,1 and data as driven, followed by a single o_net_valid pulse the cycle after the second write, with o_ready=0 from that point.
- Result return. After the start pulse, hold i_net_valid low for 10 cycles, then drive i_net_valid=1 with i_net_data=0x40400000. Required: o_q_valid pulse the next cycle, o_q_max=0x40400000 held afterwards, o_ready=1.
- Gapped input. Drive i_valid with bubbles (1,0,0,1) and BASE_ADDRESS=4. Required: writes only on accepted words, to addr 4 then 5, and exactly one o_net_valid pulse.
- Timeout. TIMEOUT_CYCLES=8, i_net_valid never asserted. Required: o_timeout pulse 8 cycles after entering WAIT, o_q_max unchanged (0), return to LOAD. A late i_net_valid after that is ignored.
- Ignored inputs. Drive i_valid during WAIT with 0xDEADBEEF. Required: no o_wr_en. Also drive i_net_valid=1 during LOAD. Required: no o_q_valid and o_q_max unchanged.
- Async reset during WAIT and mid-LOAD after 1 word. Required: all outputs 0 immediately, o_ready=1 after release, and the next load starts at BASE_ADDRESS.
